// File: rtl/sorted_vec_unloader.sv
// sorted_vec_unloader: accepts descending-sorted N-element vectors into a
// two-slot ping-pong buffer and streams them out one element per handshake,
// largest first, flagging any element that is larger than its predecessor.
module sorted_vec_unloader #(
   parameter int DW = 8,
   parameter int N  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 vec_valid,
   output logic                 vec_ready,
   input  logic [N*DW-1:0]      vec_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        out_data,
   output logic [$clog2(N)-1:0] out_idx,
   output logic                 out_last,
   output logic                 out_order_err,
   input  logic                 clr_err,
   output logic                 err_sticky
);

   localparam int IW = $clog2(N);

   // Occupancy of the ping-pong buffer.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

   occ_t              state;
   occ_t              state_next;
   logic              wp;
   logic              rp;
   logic [IW-1:0]     idx;
   logic [IW-1:0]     prev_idx;
   logic [N*DW-1:0]   slot [2];
   logic [N*DW-1:0]   rd_vec;
   logic [DW-1:0]     elem [N];
   logic [DW-1:0]     cur_elem;
   logic [DW-1:0]     prev_elem;
   logic              accept;
   logic              pop;
   logic              last_pop;
   logic              order_err;

   assign accept   = vec_valid & vec_ready;
   assign pop      = out_valid & out_ready;
   assign last_pop = pop & (&idx);

   // Occupancy next-state: accept and final pop in the same cycle cancel out.
   always_comb begin
      state_next = state;
      unique case (state)
         EMPTY: if (accept) state_next = ONE;
         ONE: begin
            if (accept && !last_pop)      state_next = FULL;
            else if (!accept && last_pop) state_next = EMPTY;
         end
         FULL: if (last_pop) state_next = ONE;
         default: state_next = EMPTY;
      endcase
   end

   // Control state: occupancy, pointers, element counter, registered ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         wp        <= 1'b0;
         rp        <= 1'b0;
         idx       <= '0;
         vec_ready <= 1'b0;
      end else begin
         state     <= state_next;
         wp        <= wp ^ accept;
         rp        <= rp ^ last_pop;
         if (pop) idx <= idx + IW'(1);
         // Ready is a pure function of next occupancy, so out_ready never
         // reaches vec_ready combinationally.
         vec_ready <= (state_next != FULL);
      end
   end

   // Vector storage; contents need no reset since out_valid gates their use.
   always_ff @(posedge clk) begin
      if (accept) slot[wp] <= vec_data;
   end

   // Unpack the slot being read into individual elements.
   always_comb begin
      rd_vec = slot[rp];
      for (int unsigned k = 0; k < N; k++) begin
         elem[k] = rd_vec[k*DW +: DW];
      end
   end

   assign prev_idx  = idx - IW'(1);
   assign cur_elem  = elem[idx];
   assign prev_elem = elem[prev_idx];
   assign order_err = (idx != '0) && (cur_elem > prev_elem);

   // Output stage: everything is forced to zero while the buffer is empty.
   always_comb begin
      out_valid     = (state != EMPTY);
      out_data      = '0;
      out_idx       = '0;
      out_last      = 1'b0;
      out_order_err = 1'b0;
      if (out_valid) begin
         out_data      = cur_elem;
         out_idx       = idx;
         out_last      = &idx;
         out_order_err = order_err;
      end
   end

   // Sticky order error: a flagged pop wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   err_sticky <= 1'b0;
      else if (pop && out_order_err) err_sticky <= 1'b1;
      else if (clr_err)             err_sticky <= 1'b0;
   end

endmodule

// File: tb/tb_sorted_vec_unloader.sv
// Scoreboard bench for sorted_vec_unloader: stimulus pushes expected elements
// on vector acceptance, a negedge monitor pops and compares on each handshake.
module tb_sorted_vec_unloader;

   localparam int DW = 8;
   localparam int N  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          vec_valid = 1'b0;
   logic          vec_ready;
   logic [N*DW-1:0] vec_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [2:0]    out_idx;
   logic          out_last;
   logic          out_order_err;
   logic          clr_err = 1'b0;
   logic          err_sticky;

   sorted_vec_unloader #(.DW(DW), .N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last), .out_order_err(out_order_err),
      .clr_err(clr_err), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic [2:0] i;
      logic       l;
      logic       e;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   pops_done = 0;
   bit   rand_rdy = 1'b0;

   function automatic logic [63:0] pack8(input logic [7:0] b0, b1, b2, b3,
                                         b4, b5, b6, b7);
      return {b7, b6, b5, b4, b3, b2, b1, b0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare the presented element against the queue head every
   // valid cycle (covers stall stability), pop on handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_valid actual=data %0h idx %0d required=no output",
                     out_data, out_idx);
         end else begin
            mon_e = q[0];
            chk("out_data", {24'd0, out_data}, {24'd0, mon_e.d});
            chk("out_idx", {29'd0, out_idx}, {29'd0, mon_e.i});
            chk("out_last", {31'd0, out_last}, {31'd0, mon_e.l});
            chk("out_order_err", {31'd0, out_order_err}, {31'd0, mon_e.e});
            if (out_ready) begin
               void'(q.pop_front());
               pops_done++;
            end
         end
      end
   end

   // Random backpressure when enabled.
   always begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   end

   // Offer a vector (called at posedge+1); expected elements queued on accept.
   task automatic send(input logic [63:0] v, input logic [7:0] mask);
      int   n;
      exp_t e;
      n = 0;
      vec_valid = 1'b1;
      vec_data  = v;
      @(negedge clk);
      while (!vec_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!vec_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=not accepted required=accepted");
         vec_valid = 1'b0;
      end else begin
         for (int k = 0; k < 8; k++) begin
            e.d = v[k*8 +: 8];
            e.i = 3'(k);
            e.l = (k == 7);
            e.e = mask[k];
            q.push_back(e);
         end
         @(posedge clk);
         #1;
         vec_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_queue", q.size(), 0);
   endtask

   task automatic pop1(input logic c);
      out_ready = 1'b1;
      clr_err   = c;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      clr_err   = 1'b0;
   endtask

   logic [63:0] va, vb, vc, vd, ve, vf, vg, vt, v1, v2, v3;

   initial begin
      int n;
      va = pack8(8'h80, 8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10);
      vb = pack8(8'hF0, 8'hE0, 8'hD0, 8'hC0, 8'hB0, 8'hA0, 8'h90, 8'h80);
      vc = pack8(8'h7F, 8'h7F, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10);
      vd = pack8(8'hE7, 8'hD6, 8'hC5, 8'hB4, 8'hA3, 8'h92, 8'h81, 8'h70);
      ve = pack8(8'h6F, 8'h5E, 8'h4D, 8'h3C, 8'h2B, 8'h1A, 8'h09, 8'h00);
      vf = pack8(8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h09, 8'h08);
      vg = pack8(8'h50, 8'h60, 8'h40, 8'h30, 8'h20, 8'h10, 8'h08, 8'h04);
      vt = pack8(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
      v1 = pack8(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08);
      v2 = pack8(8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA, 8'hF9, 8'hF8);
      v3 = pack8(8'h33, 8'h22, 8'h11, 8'h00, 8'h00, 8'h44, 8'h01, 8'h00);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vec_ready", {31'd0, vec_ready}, 0);
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_out_data", {24'd0, out_data}, 0);
      chk("rst_out_idx", {29'd0, out_idx}, 0);
      chk("rst_out_last", {31'd0, out_last}, 0);
      chk("rst_order_err", {31'd0, out_order_err}, 0);
      chk("rst_err_sticky", {31'd0, err_sticky}, 0);
      rst_n = 1'b1;
      #1;
      chk("ready_before_edge", {31'd0, vec_ready}, 0);
      @(posedge clk);
      #1;
      chk("ready_after_edge", {31'd0, vec_ready}, 1);

      // Single vector, streaming sink
      out_ready = 1'b1;
      send(va, 8'h00);
      chk("latency_valid", {31'd0, out_valid}, 1);
      chk("latency_idx", {29'd0, out_idx}, 0);
      wait_drain();
      chk("t1_sticky", {31'd0, err_sticky}, 0);

      // Two vectors buffered, then drained gaplessly
      out_ready = 1'b0;
      send(vb, 8'h00);
      send(vc, 8'h00);
      chk("full_ready_low", {31'd0, vec_ready}, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("gapless_valid", {31'd0, out_valid}, 1);
         if (i == 7) chk("ready_before_final_pop", {31'd0, vec_ready}, 0);
         if (i == 8) chk("ready_after_final_pop", {31'd0, vec_ready}, 1);
      end
      @(posedge clk);
      #1;
      chk("drained_valid", {31'd0, out_valid}, 0);
      wait_drain();

      // Third vector offered while FULL across the final pop
      out_ready = 1'b0;
      send(vd, 8'h00);
      send(ve, 8'h00);
      fork
         send(vf, 8'h00);
         begin
            out_ready = 1'b1;
            for (int i = 0; i < 9; i++) begin
               @(negedge clk);
               if (i == 7) chk("no_accept_on_final_pop", {31'd0, vec_ready}, 0);
               if (i == 8) chk("accept_next_cycle", {31'd0, vec_ready}, 1);
            end
         end
      join
      wait_drain();

      // Order error and sticky flag behaviour
      out_ready = 1'b0;
      send(vg, 8'h02);
      pop1(1'b0);
      chk("sticky_after_clean0", {31'd0, err_sticky}, 0);
      pop1(1'b0);
      chk("sticky_after_err", {31'd0, err_sticky}, 1);
      pop1(1'b1);
      chk("sticky_clr_clean_pop", {31'd0, err_sticky}, 0);
      repeat (5) pop1(1'b0);
      send(vg, 8'h02);
      pop1(1'b0);
      pop1(1'b1);
      chk("sticky_set_wins", {31'd0, err_sticky}, 1);
      repeat (6) pop1(1'b0);
      clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
      chk("sticky_clr_idle", {31'd0, err_sticky}, 0);
      wait_drain();

      // Ties are legal
      out_ready = 1'b1;
      send(vt, 8'h00);
      wait_drain();
      chk("ties_sticky", {31'd0, err_sticky}, 0);

      // Random stalls, reset at idx 3 of the second vector
      pops_done = 0;
      rand_rdy  = 1'b1;
      send(v1, 8'hFE);
      send(v2, 8'h00);
      n = 0;
      while (pops_done < 11 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("reach_idx3_pops", pops_done, 11);
      chk("idx_before_rst", {29'd0, out_idx}, 3);
      rand_rdy = 1'b0;
      rst_n = 1'b0;
      #1;
      q.delete();
      chk("mid_rst_valid", {31'd0, out_valid}, 0);
      chk("mid_rst_data", {24'd0, out_data}, 0);
      chk("mid_rst_idx", {29'd0, out_idx}, 0);
      chk("mid_rst_last", {31'd0, out_last}, 0);
      chk("mid_rst_order_err", {31'd0, out_order_err}, 0);
      chk("mid_rst_ready", {31'd0, vec_ready}, 0);
      chk("mid_rst_sticky", {31'd0, err_sticky}, 0);
      repeat (2) begin
         @(negedge clk);
         chk("rst_no_glitch", {31'd0, out_valid}, 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(v3, 8'h20);
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sorted_vec_unloader.md
# sorted_vec_unloader

Serializing consumer for the sorter's 8-wide output. It accepts a descending-sorted vector of 8 bytes through a valid/ready handshake, holds up to two vectors in a ping-pong buffer, and streams them out one element per handshake, largest first. It also checks that each vector really is in descending order and raises a sticky error flag when it is not. It sits between the sorter's output register stage and any byte-serial sink.

## Interface
- DW, 8, element width in bits
- N, 8, elements per vector (power of two, ≥2)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- vec_valid  in  1  vec_data holds a vector to transfer
- vec_ready  out  1  block can accept a vector this cycle
- vec_data  in  N*DW  element k at bits [k*DW +: DW]; element 0 = out1 of sorter (largest)
- out_valid  out  1  out_data/out_idx/out_last/out_order_err valid
- out_ready  in  1  sink accepts current element
- out_data  out  DW  current element
- out_idx  out  log2(N)  position of out_data within its vector, 0..N-1
- out_last  out  1  out_idx == N-1
- out_order_err  out  1  current element is greater than element idx-1 of same vector
- clr_err  in  1  synchronous clear of err_sticky
- err_sticky  out  1  an out-of-order element was emitted since reset/clear

## Operation
- Storage: two slots of N*DW bits, write pointer wp, read pointer rp, occupancy cnt ∈ {0,1,2}. Occupancy FSM: EMPTY(0) → ONE(1) → FULL(2).
- Accept: vec_valid & vec_ready → vec_data written to slot[wp], wp toggles.
- Emit: element counter idx (log2(N) bits). out_valid = cnt≠0. out_data = slot[rp] element idx.
- Pop: out_valid & out_ready → idx+1; when idx == N-1, idx wraps to 0, rp toggles, the slot is freed.
- Simultaneous accept and final pop: cnt unchanged. Accept alone: cnt+1. Final pop alone: cnt−1. Non-final pops leave cnt unchanged.
- vec_ready is registered: next value = (cnt_next < 2). No combinational path from out_ready to vec_ready. In FULL state, a final pop raises vec_ready the following cycle.
- Order check: out_order_err = (idx≠0) & (slot[rp][idx] > slot[rp][idx−1]), compared unsigned. Ties are legal. Element 0 never flags.
- err_sticky: set on a pop with out_order_err=1. Otherwise cleared by clr_err. Set wins over a same-cycle clr_err.
- Output stability: while out_valid & ~out_ready, all out_* outputs hold.
- Buffer contents and order are never altered; the block re-times and serializes only.

## Timing
- Reset (rst_n low, asynchronous): cnt=0, wp=rp=0, idx=0, err_sticky=0, vec_ready=0, out_valid=0, out_data=0, out_idx=0, out_last=0, out_order_err=0. Slot contents are don't-care. out_data is forced to 0 while cnt=0.
- vec_ready first reads 1 on the first rising edge after rst_n deasserts.
- Latency: a vector accepted at edge t gives out_valid=1 with idx 0 after edge t (visible in cycle t+1) when the block was EMPTY.
- Throughput: with out_ready held high, one element per cycle. Back-to-back vectors are gapless: the last element of vector A is followed by idx 0 of vector B on the next cycle.
- Full rate: a sustained source accepts one vector every N cycles with no bubble.
- Reset mid-stream: all state is discarded immediately, partial vectors are dropped, and no output glitches to valid.

## Test plan
- Reset then load 0x80,0x70,…,0x10 with out_ready=1 → vec_ready=1 one cycle after release; outputs 0x80..0x10, idx 0..7, out_last only at 0x10, err_sticky=0.
- Two vectors back-to-back with out_ready=0 → both accepted, vec_ready drops to 0. Then out_ready=1 → 16 consecutive elements with no bubble, and vec_ready returns 1 one cycle after the 8th pop.
- Third vector offered while FULL and the final pop occurs → not accepted that cycle; accepted next cycle. No data lost or duplicated across 3 vectors.
- Vector 0x50,0x60,0x40,… → out_order_err=1 only at idx 1; err_sticky=1 after that pop. clr_err pulsed on a clean pop → 0. clr_err on the same cycle as an err pop → stays 1.
- Ties: all elements 0xAA → no out_order_err, err_sticky=0.
- Random out_ready stalls and rst_n asserted at idx 3 of the 2nd vector → all outputs 0 immediately. Post-reset the next vector streams from idx 0 with correct data.
